// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: issues sequential word fetches, buffers returned instructions with
// their PCs for decode, and squashes stale responses after a redirect.
module if_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    output logic        busy
);
    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned CntW  = $clog2(DEPTH + 1);
    localparam int unsigned OutW  = $clog2(MAX_OUT + 1);
    localparam int unsigned SPtrW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    typedef enum logic [0:0] {StFetch, StFlush} state_e;

    state_e            state_q, state_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [OutW-1:0]   out_q, out_d;
    logic [OutW-1:0]   disc_q, disc_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [PtrW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [SPtrW-1:0]  swr_q, swr_d, srd_q, srd_d;

    logic [31:0]       fifo_data_q [DEPTH];
    logic [31:0]       fifo_pc_q   [DEPTH];
    logic [31:0]       shadow_q    [MAX_OUT];

    logic issue, rsp, push, pop;

    // Credit check keeps fifo entries plus in-flight requests within DEPTH, so pushes never overflow.
    assign imem_req_valid = ~reset & (state_q == StFetch) & ~stall & ~redirect_valid
                          & (32'(out_q) < MAX_OUT)
                          & ((32'(cnt_q) + 32'(out_q)) < DEPTH);
    assign imem_req_addr  = fetch_pc_q;

    assign instr_valid = (cnt_q != '0);
    assign instr_data  = fifo_data_q[rptr_q];
    assign instr_pc    = fifo_pc_q[rptr_q];
    assign busy        = (out_q != '0) | (state_q == StFlush);

    assign issue = imem_req_valid & imem_req_ready;
    assign rsp   = imem_rsp_valid;
    assign pop   = instr_valid & instr_ready;
    assign push  = rsp & (disc_q == '0) & ~redirect_valid;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        out_d      = out_q;
        disc_d     = disc_q;
        cnt_d      = cnt_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        swr_d      = swr_q;
        srd_d      = srd_q;

        if (issue) begin
            fetch_pc_d = fetch_pc_q + 32'd1;
            swr_d      = (swr_q == SPtrW'(MAX_OUT - 1)) ? '0 : swr_q + SPtrW'(1);
        end
        // The PC shadow queue tracks every request, stale or not, so it stays aligned.
        if (rsp) begin
            srd_d = (srd_q == SPtrW'(MAX_OUT - 1)) ? '0 : srd_q + SPtrW'(1);
        end

        case ({issue, rsp})
            2'b10:   out_d = out_q + OutW'(1);
            2'b01:   out_d = out_q - OutW'(1);
            default: out_d = out_q;
        endcase

        if (push) wptr_d = wptr_q + PtrW'(1);
        if (pop)  rptr_d = rptr_q + PtrW'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase

        if (rsp && (disc_q != '0)) disc_d = disc_q - OutW'(1);

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            wptr_d     = '0;
            rptr_d     = '0;
            cnt_d      = '0;
            disc_d     = out_d;
        end

        case (state_q)
            StFetch: if (disc_d != '0) state_d = StFlush;
            StFlush: if (disc_d == '0) state_d = StFetch;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StFetch;
            fetch_pc_q <= RESET_PC;
            out_q      <= '0;
            disc_q     <= '0;
            cnt_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            swr_q      <= '0;
            srd_q      <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            out_q      <= out_d;
            disc_q     <= disc_d;
            cnt_q      <= cnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            swr_q      <= swr_d;
            srd_q      <= srd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            fifo_data_q[wptr_q] <= imem_rsp_data;
            fifo_pc_q[wptr_q]   <= shadow_q[srd_q];
        end
        if (issue) shadow_q[swr_q] <= fetch_pc_q;
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a 1-cycle in-order instruction memory model.
module tb_if_fetch_queue;
    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] pend[$];
    logic        rsp_auto;
    logic        req_fired, pop_fired;
    logic [31:0] req_addr, pop_pc, pop_data;

    if_fetch_queue #(.DEPTH(4), .MAX_OUT(2), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dfun(input logic [31:0] a);
        return ~a ^ 32'h1357_9BDF;
    endfunction

    task automatic drive_rsp();
        if (pend.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = dfun(pend[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    endtask

    // One clock: capture handshakes before the edge, then update the memory model.
    task automatic cyc();
        logic rf, sf;
        logic [31:0] ra;
        #1;
        rf = imem_req_valid & imem_req_ready;
        ra = imem_req_addr;
        sf = imem_rsp_valid;
        req_fired = rf;
        req_addr  = ra;
        pop_fired = instr_valid & instr_ready;
        pop_pc    = instr_pc;
        pop_data  = instr_data;
        @(posedge clk);
        #1;
        if (sf && pend.size() > 0) void'(pend.pop_front());
        if (rf) pend.push_back(ra);
        if (rsp_auto) drive_rsp();
    endtask

    task automatic do_reset();
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
        imem_req_ready = 1'b0; instr_ready = 1'b0; rsp_auto = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        cyc();
        cyc();
        pend.delete();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
        imem_req_ready = 1'b1; instr_ready = 1'b1; rsp_auto = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        cyc();
        cyc();
        #1;
        n_cmp++; if (imem_req_valid !== 1'b0) begin
            $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); n_fail++; end
        n_cmp++; if (instr_valid !== 1'b0) begin
            $display("FAIL reset_instr_valid: got %b want 0", instr_valid); n_fail++; end
        n_cmp++; if (busy !== 1'b0) begin
            $display("FAIL reset_busy: got %b want 0", busy); n_fail++; end
        n_cmp++; if (imem_req_addr !== 32'h0) begin
            $display("FAIL reset_addr: got %h want 00000000", imem_req_addr); n_fail++; end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc, exp_addr;
        int npop;
        do_reset();
        imem_req_ready = 1'b1; instr_ready = 1'b1; rsp_auto = 1'b1;
        #1;
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            $display("FAIL seq_first_req: got v=%b a=%h want v=1 a=0", imem_req_valid,
                     imem_req_addr); n_fail++; end
        cyc();
        n_cmp++; if (instr_valid !== 1'b0) begin
            $display("FAIL seq_latency: got instr_valid=%b want 0", instr_valid); n_fail++; end
        cyc();
        #1;
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr_data !== dfun(32'h0)) begin
            $display("FAIL seq_first_instr: got v=%b pc=%h d=%h want v=1 pc=0 d=%h",
                     instr_valid, instr_pc, instr_data, dfun(32'h0)); n_fail++; end
        exp_pc = 32'h0; exp_addr = 32'h2; npop = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (pop_fired) begin
                n_cmp++; if (pop_pc !== exp_pc || pop_data !== dfun(exp_pc)) begin
                    $display("FAIL seq_pop: got pc=%h d=%h want pc=%h d=%h", pop_pc, pop_data,
                             exp_pc, dfun(exp_pc)); n_fail++; end
                exp_pc++; npop++;
            end
            if (req_fired) begin
                n_cmp++; if (req_addr !== exp_addr) begin
                    $display("FAIL seq_addr: got %h want %h", req_addr, exp_addr); n_fail++; end
                exp_addr++;
            end
        end
        n_cmp++; if (npop !== 8) begin
            $display("FAIL seq_pop_count: got %0d want 8", npop); n_fail++; end
    endtask

    task automatic test_backpressure();
        int nreq, npop;
        logic [31:0] exp_pc, exp_addr;
        do_reset();
        imem_req_ready = 1'b1; instr_ready = 1'b0; rsp_auto = 1'b1;
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (req_fired) nreq++;
        end
        #1;
        n_cmp++; if (nreq !== 4) begin
            $display("FAIL bp_req_count: got %0d want 4", nreq); n_fail++; end
        n_cmp++; if (imem_req_valid !== 1'b0) begin
            $display("FAIL bp_req_valid: got %b want 0", imem_req_valid); n_fail++; end
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            $display("FAIL bp_head: got v=%b pc=%h want v=1 pc=0", instr_valid, instr_pc);
            n_fail++; end
        instr_ready = 1'b1;
        exp_pc = 32'h0; exp_addr = 32'h4; npop = 0;
        for (int i = 0; i < 40 && npop < 8; i++) begin
            cyc();
            if (pop_fired) begin
                n_cmp++; if (pop_pc !== exp_pc || pop_data !== dfun(exp_pc)) begin
                    $display("FAIL bp_pop: got pc=%h d=%h want pc=%h d=%h", pop_pc, pop_data,
                             exp_pc, dfun(exp_pc)); n_fail++; end
                exp_pc++; npop++;
            end
            if (req_fired) begin
                n_cmp++; if (req_addr !== exp_addr) begin
                    $display("FAIL bp_addr: got %h want %h", req_addr, exp_addr); n_fail++; end
                exp_addr++;
            end
        end
        n_cmp++; if (npop !== 8) begin
            $display("FAIL bp_resume_count: got %0d want 8", npop); n_fail++; end
    endtask

    task automatic test_redirect();
        do_reset();
        imem_req_ready = 1'b1; instr_ready = 1'b1; rsp_auto = 1'b0;
        cyc();
        cyc();
        #1;
        n_cmp++; if (imem_req_valid !== 1'b0) begin
            $display("FAIL rd_max_out: got req_valid=%b want 0", imem_req_valid); n_fail++; end
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        cyc();
        redirect_valid = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b1 || imem_req_valid !== 1'b0) begin
            $display("FAIL rd_flush_enter: got busy=%b v=%b want busy=1 v=0", busy,
                     imem_req_valid); n_fail++; end
        rsp_auto = 1'b1;
        drive_rsp();
        cyc();
        #1;
        n_cmp++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL rd_drop1: got iv=%b v=%b busy=%b want 0 0 1", instr_valid,
                     imem_req_valid, busy); n_fail++; end
        cyc();
        #1;
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40 || busy !== 1'b0
                     || instr_valid !== 1'b0) begin
            $display("FAIL rd_resume: got v=%b a=%h busy=%b iv=%b want 1 00000040 0 0",
                     imem_req_valid, imem_req_addr, busy, instr_valid); n_fail++; end
        cyc();
        n_cmp++; if (instr_valid !== 1'b0) begin
            $display("FAIL rd_no_stale: got iv=%b want 0", instr_valid); n_fail++; end
        cyc();
        #1;
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr_data !== dfun(32'h40)) begin
            $display("FAIL rd_first_pc: got v=%b pc=%h d=%h want v=1 pc=00000040 d=%h",
                     instr_valid, instr_pc, instr_data, dfun(32'h40)); n_fail++; end
    endtask

    task automatic test_redirect_pop();
        do_reset();
        imem_req_ready = 1'b1; instr_ready = 1'b0; rsp_auto = 1'b1;
        cyc();
        cyc();
        redirect_valid = 1'b1; redirect_pc = 32'h100; instr_ready = 1'b1;
        #1;
        n_cmp++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b1) begin
            $display("FAIL rp_setup: got v=%b iv=%b want v=0 iv=1", imem_req_valid, instr_valid);
            n_fail++; end
        cyc();
        redirect_valid = 1'b0;
        n_cmp++; if (pop_fired !== 1'b1 || pop_pc !== 32'h0) begin
            $display("FAIL rp_pop: got fired=%b pc=%h want 1 00000000", pop_fired, pop_pc);
            n_fail++; end
        #1;
        n_cmp++; if (instr_valid !== 1'b0 || busy !== 1'b0 || imem_req_valid !== 1'b1
                     || imem_req_addr !== 32'h100) begin
            $display("FAIL rp_after: got iv=%b busy=%b v=%b a=%h want 0 0 1 00000100",
                     instr_valid, busy, imem_req_valid, imem_req_addr); n_fail++; end
        cyc();
        n_cmp++; if (instr_valid !== 1'b0) begin
            $display("FAIL rp_empty: got iv=%b want 0", instr_valid); n_fail++; end
        cyc();
        #1;
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin
            $display("FAIL rp_new_head: got v=%b pc=%h want 1 00000100", instr_valid, instr_pc);
            n_fail++; end
    endtask

    task automatic test_stall();
        do_reset();
        imem_req_ready = 1'b1; instr_ready = 1'b0; rsp_auto = 1'b0;
        cyc();
        cyc();
        stall = 1'b1; rsp_auto = 1'b1;
        drive_rsp();
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++; if (imem_req_valid !== 1'b0) begin
                $display("FAIL st_no_req: cycle %0d got v=%b want 0", i, imem_req_valid);
                n_fail++; end
            cyc();
        end
        #1;
        n_cmp++; if (busy !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            $display("FAIL st_queued: got busy=%b iv=%b pc=%h want 0 1 00000000", busy,
                     instr_valid, instr_pc); n_fail++; end
        stall = 1'b0;
        #1;
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h2) begin
            $display("FAIL st_resume: got v=%b a=%h want 1 00000002", imem_req_valid,
                     imem_req_addr); n_fail++; end
        instr_ready = 1'b1;
        cyc();
        n_cmp++; if (pop_fired !== 1'b1 || pop_pc !== 32'h0) begin
            $display("FAIL st_pop0: got fired=%b pc=%h want 1 00000000", pop_fired, pop_pc);
            n_fail++; end
        cyc();
        n_cmp++; if (pop_fired !== 1'b1 || pop_pc !== 32'h1 || pop_data !== dfun(32'h1)) begin
            $display("FAIL st_pop1: got fired=%b pc=%h d=%h want 1 00000001 %h", pop_fired,
                     pop_pc, pop_data, dfun(32'h1)); n_fail++; end
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        imem_req_ready = 1'b1; instr_ready = 1'b0; rsp_auto = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        cyc();
        redirect_valid = 1'b0;
        #1;
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFF) begin
            $display("FAIL wr_top: got v=%b a=%h want 1 ffffffff", imem_req_valid,
                     imem_req_addr); n_fail++; end
        cyc();
        #1;
        n_cmp++; if (imem_req_addr !== 32'h0) begin
            $display("FAIL wr_wrap: got a=%h want 00000000", imem_req_addr); n_fail++; end
        cyc();
        #1;
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFF) begin
            $display("FAIL wr_head_pc: got v=%b pc=%h want 1 ffffffff", instr_valid, instr_pc);
            n_fail++; end
        rsp_auto = 1'b0; imem_rsp_valid = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        cyc();
        redirect_valid = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b1 || imem_req_valid !== 1'b0) begin
            $display("FAIL wr_flush: got busy=%b v=%b want 1 0", busy, imem_req_valid);
            n_fail++; end
        reset = 1'b1;
        cyc();
        pend.delete();
        reset = 1'b0;
        #1;
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 || busy !== 1'b0
                     || instr_valid !== 1'b0) begin
            $display("FAIL wr_reset_flush: got v=%b a=%h busy=%b iv=%b want 1 00000000 0 0",
                     imem_req_valid, imem_req_addr, busy, instr_valid); n_fail++; end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_redirect_pop();
        test_stall();
        test_wrap_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
